// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 receive path: FSM states, error codes
// and default 100 MHz line timing.
package ws2812_pkg;

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_e;

  localparam logic [1:0] ERR_GLITCH     = 2'd0;
  localparam logic [1:0] ERR_STUCK_HIGH = 2'd1;
  localparam logic [1:0] ERR_PARTIAL    = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW   = 2'd3;

  localparam int T_MIN_HIGH_DEF = 10;
  localparam int T_SPLIT_DEF    = 60;
  localparam int T_MAX_HIGH_DEF = 120;
  localparam int T_LATCH_DEF    = 5000;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer plus one delay flop for edge detection. No filtering,
// so high-pulse widths reach the decoder cycle-exact.
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);
  logic din_m, din_p;

  always_ff @(posedge clk) begin
    if (!reset) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_p <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_p <= din_s;
    end
  end

  assign rise = din_s & ~din_p;
  assign fall = ~din_s & din_p;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 line decoder: measures high pulses, assembles MSB-first pixels,
// flags end-of-frame on the latch gap and reports protocol errors.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int PX_COUNT_WIDTH = 6,
  parameter int PX_NUM         = 52,
  parameter int BITS_PER_PIXEL = 24,
  parameter int T_MIN_HIGH     = T_MIN_HIGH_DEF,
  parameter int T_SPLIT        = T_SPLIT_DEF,
  parameter int T_MAX_HIGH     = T_MAX_HIGH_DEF,
  parameter int T_LATCH        = T_LATCH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel,
  output logic                      pixel_valid,
  output logic [PX_COUNT_WIDTH-1:0] pixel_idx,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH:0]   frame_px_count,
  output logic                      err_valid,
  output logic [1:0]                err_code
);
  localparam int HW = $clog2(T_MAX_HIGH + 2);
  localparam int LW = $clog2(T_LATCH + 1);
  localparam int BW = $clog2(BITS_PER_PIXEL + 1);
  localparam int PW = PX_COUNT_WIDTH + 1;

  localparam logic [HW-1:0] H_MIN   = HW'(T_MIN_HIGH);
  localparam logic [HW-1:0] H_SPLIT = HW'(T_SPLIT);
  localparam logic [HW-1:0] H_MAX   = HW'(T_MAX_HIGH);
  localparam logic [HW-1:0] H_SAT   = HW'(T_MAX_HIGH + 1);
  localparam logic [LW-1:0] L_LAST  = LW'(T_LATCH - 1);
  localparam logic [LW-1:0] L_SAT   = LW'(T_LATCH);
  localparam logic [BW-1:0] B_LAST  = BW'(BITS_PER_PIXEL - 1);
  localparam logic [PW-1:0] P_MAX   = PW'(PX_NUM);

  logic din_s, rise, fall;

  ws2812_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_e                 state, nstate;
  logic [HW-1:0]             hcnt;
  logic [LW-1:0]             lcnt;
  logic [BW-1:0]             bitcnt;
  logic [BITS_PER_PIXEL-2:0] shreg;
  logic [PW-1:0]             px_cnt;
  logic                      ovf_seen;

  logic ev_stuck, ev_glitch, ev_bit, ev_latch;
  logic ev_done, accept, ev_ovf, err_sync, bit_val, lat_hit;
  logic pv_d, fd_d, err_d;
  logic [1:0] code_d;

  assign bit_val  = (hcnt >= H_SPLIT);
  // Current cycle is low and completes the T_LATCH-th consecutive low cycle.
  assign lat_hit  = !din_s && (lcnt == L_LAST);
  assign ev_done  = ev_bit && (bitcnt == B_LAST);
  assign accept   = ev_done && (px_cnt < P_MAX);
  assign ev_ovf   = ev_done && !accept && !ovf_seen;
  assign err_sync = ev_stuck | ev_glitch;

  always_ff @(posedge clk) begin
    if (!reset) state <= SYNC;
    else        state <= nstate;
  end

  always_comb begin
    nstate    = state;
    ev_stuck  = 1'b0;
    ev_glitch = 1'b0;
    ev_bit    = 1'b0;
    ev_latch  = 1'b0;
    case (state)
      SYNC: if (lat_hit) nstate = IDLE;
      IDLE: if (rise) nstate = HIGH;
      HIGH: begin
        if (hcnt > H_MAX) begin
          ev_stuck = 1'b1;
          nstate   = SYNC;
        end else if (fall) begin
          if (hcnt < H_MIN) begin
            ev_glitch = 1'b1;
            nstate    = SYNC;
          end else begin
            ev_bit = 1'b1;
            nstate = LOW;
          end
        end
      end
      LOW: begin
        if (rise) nstate = HIGH;
        else if (lat_hit) begin
          ev_latch = 1'b1;
          nstate   = IDLE;
        end
      end
      default: nstate = SYNC;
    endcase
  end

  always_comb begin
    pv_d   = accept;
    fd_d   = ev_latch;
    err_d  = 1'b0;
    code_d = ERR_GLITCH;
    if (ev_glitch) begin
      err_d  = 1'b1;
      code_d = ERR_GLITCH;
    end else if (ev_stuck) begin
      err_d  = 1'b1;
      code_d = ERR_STUCK_HIGH;
    end else if (ev_ovf) begin
      err_d  = 1'b1;
      code_d = ERR_OVERFLOW;
    end else if (ev_latch && bitcnt != '0) begin
      err_d  = 1'b1;
      code_d = ERR_PARTIAL;
    end
  end

  // Counters and frame bookkeeping. hcnt is preloaded with 1 outside HIGH so
  // the rising-edge cycle is already counted when HIGH is entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hcnt     <= '0;
      lcnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      px_cnt   <= '0;
      ovf_seen <= 1'b0;
    end else begin
      if (state != HIGH)               hcnt <= HW'(1);
      else if (din_s && hcnt != H_SAT) hcnt <= hcnt + 1'b1;

      if (err_sync)    lcnt <= '0;
      else if (ev_bit) lcnt <= LW'(1);
      else if (state == SYNC || state == LOW) begin
        if (din_s)              lcnt <= '0;
        else if (lcnt != L_SAT) lcnt <= lcnt + 1'b1;
      end

      if (err_sync || ev_latch) begin
        bitcnt   <= '0;
        px_cnt   <= '0;
        ovf_seen <= 1'b0;
      end else if (ev_bit) begin
        shreg  <= {shreg[BITS_PER_PIXEL-3:0], bit_val};
        bitcnt <= ev_done ? '0 : bitcnt + 1'b1;
        if (accept) px_cnt   <= px_cnt + 1'b1;
        if (ev_ovf) ovf_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel          <= '0;
      pixel_valid    <= 1'b0;
      pixel_idx      <= '0;
      frame_done     <= 1'b0;
      frame_px_count <= '0;
      err_valid      <= 1'b0;
      err_code       <= '0;
    end else begin
      pixel_valid <= pv_d;
      frame_done  <= fd_d;
      err_valid   <= err_d;
      if (err_d) err_code <= code_d;
      if (accept) begin
        pixel          <= {shreg, bit_val};
        pixel_idx      <= px_cnt[PX_COUNT_WIDTH-1:0];
        frame_px_count <= px_cnt + 1'b1;
      end else if (ev_latch) begin
        frame_px_count <= px_cnt;
      end
    end
  end
endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives WS2812 waveforms and checks decoded
// pixels, frame/latch strobes, error codes and strobe latency.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [5:0]  pixel_idx;
  logic        frame_done;
  logic [6:0]  frame_px_count;
  logic        err_valid;
  logic [1:0]  err_code;

  ws2812_rx dut (
    .clk            (clk),
    .reset          (reset),
    .din            (din),
    .pixel          (pixel),
    .pixel_valid    (pixel_valid),
    .pixel_idx      (pixel_idx),
    .frame_done     (frame_done),
    .frame_px_count (frame_px_count),
    .err_valid      (err_valid),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int pv_px[$], pv_idx[$], pv_cyc[$], fd_n[$], fd_err[$], er_code[$], er_cyc[$];
  int last_fall, ovf_fall, rise_at;

  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_px.push_back(int'(pixel));
      pv_idx.push_back(int'(pixel_idx));
      pv_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_n.push_back(int'(frame_px_count));
      fd_err.push_back(err_valid ? int'(err_code) : -1);
    end
    if (err_valid) begin
      er_code.push_back(int'(err_code));
      er_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    pv_px.delete(); pv_idx.delete(); pv_cyc.delete();
    fd_n.delete(); fd_err.delete(); er_code.delete(); er_cyc.delete();
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_px(input logic [23:0] v, input int h0, input int l0,
                         input int h1, input int l1);
    for (int i = 23; i >= 0; i--) begin
      if (v[i]) pulse(h1, l1);
      else      pulse(h0, l0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pixel"}, 32'(pixel), 0);
    chk({tag, "_pv"}, 32'(pixel_valid), 0);
    chk({tag, "_idx"}, 32'(pixel_idx), 0);
    chk({tag, "_fd"}, 32'(frame_done), 0);
    chk({tag, "_fcnt"}, 32'(frame_px_count), 0);
    chk({tag, "_ev"}, 32'(err_valid), 0);
    chk({tag, "_ec"}, 32'(err_code), 0);
  endtask

  initial begin
    logic [23:0] v;
    int hi;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b1;
    idle(5010);

    // 1: single pixel with nominal widths, latency and frame end
    clr();
    send_px(24'hA5F00F, 40, 85, 80, 45);
    idle(5010);
    chk("t1_pv_n", pv_px.size(), 1);
    if (pv_px.size() > 0) begin
      chk("t1_px", pv_px[0], 32'hA5F00F);
      chk("t1_idx", pv_idx[0], 0);
      chk("t1_lat", pv_cyc[0] - last_fall, 3);
    end
    chk("t1_fd_n", fd_n.size(), 1);
    if (fd_n.size() > 0) begin
      chk("t1_fcnt", fd_n[0], 1);
      chk("t1_fd_err", fd_err[0], -1);
    end
    chk("t1_err_n", er_code.size(), 0);

    // 2: full frame 0..51, pixel 5 carries boundary widths 59/60/10/120
    clr();
    for (int p = 0; p < 52; p++) begin
      v = 24'(p);
      for (int i = 23; i >= 0; i--) begin
        hi = v[i] ? 64 : 11;
        if (p == 5 && i == 3) hi = 59;
        if (p == 5 && i == 2) hi = 60;
        if (p == 5 && i == 1) hi = 10;
        if (p == 5 && i == 0) hi = 120;
        pulse(hi, 1);
      end
    end
    idle(5010);
    chk("t2_pv_n", pv_px.size(), 52);
    for (int k = 0; k < pv_px.size(); k++) begin
      chk($sformatf("t2_px%0d", k), pv_px[k], k);
      chk($sformatf("t2_idx%0d", k), pv_idx[k], k);
    end
    chk("t2_fd_n", fd_n.size(), 1);
    if (fd_n.size() > 0) chk("t2_fcnt", fd_n[0], 52);
    chk("t2_err_n", er_code.size(), 0);

    // 3: 53 pixels, the last overflows
    clr();
    for (int p = 0; p < 53; p++) send_px(24'h0, 11, 1, 64, 1);
    ovf_fall = last_fall;
    idle(5010);
    chk("t3_pv_n", pv_px.size(), 52);
    if (pv_idx.size() == 52) chk("t3_last_idx", pv_idx[51], 51);
    chk("t3_err_n", er_code.size(), 1);
    if (er_code.size() > 0) begin
      chk("t3_err_code", er_code[0], 3);
      chk("t3_err_lat", er_cyc[0] - ovf_fall, 3);
    end
    chk("t3_fd_n", fd_n.size(), 1);
    if (fd_n.size() > 0) begin
      chk("t3_fcnt", fd_n[0], 52);
      chk("t3_fd_err", fd_err[0], -1);
    end

    // 4: partial pixel at latch
    clr();
    repeat (12) pulse(11, 1);
    idle(5010);
    chk("t4_pv_n", pv_px.size(), 0);
    chk("t4_fd_n", fd_n.size(), 1);
    if (fd_n.size() > 0) begin
      chk("t4_fcnt", fd_n[0], 0);
      chk("t4_fd_err", fd_err[0], 2);
    end
    chk("t4_err_n", er_code.size(), 1);

    // 5a: glitch, following bits ignored until a full latch gap
    clr();
    pulse(9, 5);
    repeat (8) pulse(64, 1);
    idle(5010);
    chk("t5_err_n", er_code.size(), 1);
    if (er_code.size() > 0) chk("t5_err_code", er_code[0], 0);
    chk("t5_pv_n", pv_px.size(), 0);
    chk("t5_fd_n", fd_n.size(), 0);

    // 5b: line stuck high
    clr();
    din = 1'b1;
    rise_at = cyc;
    repeat (200) @(negedge clk);
    idle(5010);
    chk("t5s_err_n", er_code.size(), 1);
    if (er_code.size() > 0) begin
      chk("t5s_err_code", er_code[0], 1);
      chk("t5s_err_lat", er_cyc[0] - rise_at, 124);
    end
    chk("t5s_pv_n", pv_px.size(), 0);
    chk("t5s_fd_n", fd_n.size(), 0);

    // 6: reset mid-pixel, rest ignored, fresh frame afterwards
    clr();
    for (int i = 0; i < 10; i++) pulse((i % 2) ? 64 : 11, 1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6_rst");
    reset = 1'b1;
    repeat (14) pulse(64, 1);
    idle(5010);
    chk("t6_ign_pv", pv_px.size(), 0);
    chk("t6_ign_fd", fd_n.size(), 0);
    chk("t6_ign_err", er_code.size(), 0);
    clr();
    send_px(24'h810001, 11, 1, 64, 1);
    idle(5010);
    chk("t6_pv_n", pv_px.size(), 1);
    if (pv_px.size() > 0) begin
      chk("t6_px", pv_px[0], 32'h810001);
      chk("t6_idx", pv_idx[0], 0);
    end
    chk("t6_fd_n", fd_n.size(), 1);
    if (fd_n.size() > 0) chk("t6_fcnt", fd_n[0], 1);
    chk("t6_err_n", er_code.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
